apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB initiator: takes single-beat read/write requests from an internal client (core/DMA/test
//  port) and drives one APB transfer at a time toward GPIO and other peripheral slave interfaces.
//  Sequences SETUP/ACCESS phases, honours PREADY wait states, enforces a wait-state timeout and
//  returns read data plus error status on a one-cycle response strobe.
// PARAMETERS
//  TIMEOUT_CYCLES  16            max ACCESS cycles with PREADY=0 before abort; 0 disables timeout
//  TIMEOUT_RDATA   32'hBAD1BAD1  rsp_rdata returned on timeout or misaligned request
// PORTS
//  clk         in   1   system clock, all logic on posedge
//  n_rst       in   1   asynchronous active-low reset
//  req_valid   in   1   client request present
//  req_ready   out  1   bridge can accept request (high only in IDLE)
//  req_write   in   1   1=write, 0=read
//  req_addr    in   32  byte address, must be word aligned
//  req_wdata   in   32  write data
//  rsp_valid   out  1   one-cycle response strobe
//  rsp_rdata   out  32  read data (0 for writes), valid with rsp_valid
//  rsp_error   out  1   PSLVERR, timeout or misalignment, valid with rsp_valid
//  PSEL        out  1   APB select
//  PENABLE     out  1   APB access phase
//  PWRITE      out  1   APB direction
//  PADDR       out  32  APB address
//  PWDATA      out  32  APB write data
//  PRDATA      in   32  APB read data
//  PREADY      in   1   slave ready; tie 1 for zero-wait slaves
//  pslverr     in   1   slave error
// BEHAVIOUR
//  Clocking/reset: single clock clk; reset asynchronous, active-low on n_rst.
//  Reset: state=IDLE; PSEL=PENABLE=PWRITE=0; PADDR=PWDATA=0; rsp_valid=rsp_error=0; rsp_rdata=0;
//    timeout counter=0; req_ready=1 once reset releases. Reset mid-transfer aborts immediately:
//    PSEL/PENABLE drop asynchronously, no response is issued.
//  FSM states IDLE, SETUP, ACCESS. req_ready = (state==IDLE), combinational.
//  IDLE: req_valid&&req_ready with req_addr[1:0]==0 -> latch write/addr/wdata onto PWRITE/PADDR/
//    PWDATA, go SETUP. With req_addr[1:0]!=0 -> stay IDLE, no bus activity; next cycle
//    rsp_valid=1, rsp_error=1, rsp_rdata=TIMEOUT_RDATA.
//  SETUP (1 cycle): PSEL=1, PENABLE=0 -> ACCESS unconditionally.
//  ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable from SETUP through end of ACCESS.
//    PREADY=1 -> sample PRDATA and pslverr at this edge, go IDLE; next cycle rsp_valid=1,
//    rsp_error=pslverr, rsp_rdata=PRDATA for reads and 0 for writes.
//    PREADY=0 -> stay, counter++. Counter==TIMEOUT_CYCLES (nonzero) -> go IDLE, PSEL/PENABLE
//    drop, next cycle rsp_valid=1, rsp_error=1, rsp_rdata=TIMEOUT_RDATA.
//  PRDATA/pslverr ignored whenever PENABLE=0 or PREADY=0.
//  Counter width $clog2(TIMEOUT_CYCLES+1); cleared on entry to SETUP; saturates, never wraps.
//  Leaving ACCESS: PSEL=PENABLE=0; PADDR/PWDATA/PWRITE hold last values.
//  Latency: zero-wait transfer = 3 cycles accept->rsp_valid (SETUP, ACCESS, resp); +1 per wait
//    cycle. New request acceptable in the rsp_valid cycle. Max 1 outstanding; no PSEL gaps reqd.
//  rsp_valid is a pulse; client must not stall it. rsp_rdata/rsp_error hold until next response.
// TESTING
//  1 Read 0x4, PREADY=1, PRDATA=0x1234_5678 -> PSEL 2 cycles, PENABLE 2nd only; rsp_valid 3
//    cycles after accept; rsp_rdata=0x12345678, rsp_error=0.
//  2 Write 0x0 data 0xA5A5_0001, PREADY=1 -> PWRITE=1, PWDATA stable SETUP+ACCESS;
//    rsp_error=0, rsp_rdata=0.
//  3 Read, PREADY low 3 cycles then high, pslverr=1 -> ACCESS 4 cycles; rsp_error=1;
//    rsp_rdata=PRDATA from final cycle.
//  4 Read, PREADY stuck 0, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles;
//    rsp_error=1, rsp_rdata=0xBAD1BAD1, PSEL=0.
//  5 Request to 0x6 -> no PSEL ever; rsp_valid next cycle with rsp_error=1, rdata=0xBAD1BAD1.
//  6 n_rst low during ACCESS -> PSEL/PENABLE 0 immediately, no rsp_valid; after release,
//    req_ready=1 and a following read to 0x4 completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB initiator for single-beat client requests.
//
// Accepts one read/write request at a time from an internal client, runs the APB SETUP and
// ACCESS phases, honours PREADY wait states with an optional timeout, and returns read data
// plus error status on a one-cycle response strobe. Misaligned requests never reach the bus.
//
// Ports
//   clk, n_rst                     clock, asynchronous active-low reset
//   req_valid/req_ready            client request handshake (ready only while idle)
//   req_write/req_addr/req_wdata   request direction, byte address, write data
//   rsp_valid                      one-cycle response strobe
//   rsp_rdata/rsp_error            response data/status, held until the next response
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request outputs
//   PRDATA/PREADY/pslverr          APB completion inputs
module apb_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hBAD1BAD1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        pslverr
);

  // A zero timeout disables the abort; keep the counter at least one bit wide regardless.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  // Abort decision is made on the edge that ends the TIMEOUT_CYCLES-th waiting ACCESS cycle.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e          state_q, state_d;
  logic            pwrite_q, pwrite_d;
  logic [31:0]     paddr_q, paddr_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_error_q, rsp_error_d;

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_addr[1:0] == 2'b00) begin
            pwrite_d = req_write;
            paddr_d  = req_addr;
            pwdata_d = req_wdata;
            cnt_d    = '0;
            state_d  = StSetup;
          end else begin
            // Misaligned: answer immediately without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = TIMEOUT_RDATA;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_error_d = pslverr;
          rsp_rdata_d = pwrite_q ? 32'h0 : PRDATA;
        end else begin
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
          end
          if (TimeoutEn && (cnt_q == CntLast)) begin
            state_d     = StIdle;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = TIMEOUT_RDATA;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'h0;
      pwdata_q    <= 32'h0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Select/enable decode straight from the state flop so reset drops them asynchronously.
  assign PSEL      = (state_q != StIdle);
  assign PENABLE   = (state_q == StAccess);
  assign req_ready = (state_q == StIdle);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: scoreboard of expected responses plus a bus monitor.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        pslverr;

  apb_master_bridge dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // Slave model: PREADY rises after wait_cycles ACCESS cycles; PRDATA/pslverr are junk until then.
  int          wait_cycles = 0;
  bit          stuck = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err = 1'b0;
  int          wait_cnt;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) wait_cnt <= 0;
    else if (PSEL && PENABLE && !PREADY) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign PREADY  = !stuck && (wait_cnt >= wait_cycles);
  assign PRDATA  = PREADY ? slv_rdata : {16'hDEAD, wait_cnt[15:0]};
  assign pslverr = PREADY ? slv_err : 1'b1;

  // Bus monitor: cycle counts and address/data stability across SETUP->ACCESS.
  int          psel_cnt = 0;
  int          pen_cnt = 0;
  int          stab_err = 0;
  int          rsp_cnt = 0;
  logic [31:0] snap_addr = 32'h0;
  logic [31:0] snap_wdata = 32'h0;
  logic        snap_write = 1'b0;

  always @(negedge clk) begin
    if (PSEL) psel_cnt <= psel_cnt + 1;
    if (PENABLE) pen_cnt <= pen_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (PSEL && !PENABLE) begin
      snap_addr  <= PADDR;
      snap_wdata <= PWDATA;
      snap_write <= PWRITE;
    end else if (PSEL && PENABLE &&
                 (PADDR !== snap_addr || PWDATA !== snap_wdata || PWRITE !== snap_write)) begin
      stab_err <= stab_err + 1;
    end
    if (PENABLE && !PSEL) stab_err <= stab_err + 1;
  end

  // Caller must be at negedge+1 with the bridge idle; returns at posedge+1 after acceptance.
  task automatic issue_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
  endtask

  task automatic wait_rsp(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      cyc++;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    #12;
    total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== 67'h0) begin
      bad++;
      $display("FAIL reset_bus: got %h want 0", {PSEL, PENABLE, PWRITE, PADDR, PWDATA});
    end
    total++;
    if ({rsp_valid, rsp_error, rsp_rdata} !== 34'h0) begin
      bad++;
      $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_error, rsp_rdata});
    end
    @(negedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_read;
    int cyc, p0, e0, s0;
    bit got;
    exp_t e;
    wait_cycles = 0;
    slv_rdata = 32'h1234_5678;
    slv_err = 1'b0;
    sb.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    p0 = psel_cnt; e0 = pen_cnt; s0 = stab_err;
    issue_req(1'b0, 32'h4, 32'h0);
    wait_rsp(cyc, got);
    e = sb.pop_front();
    total++;
    if (!got || cyc != 3) begin
      bad++;
      $display("FAIL read_latency: got %0d (seen %b) want 3", cyc, got);
    end
    total++;
    if (psel_cnt - p0 != 2 || pen_cnt - e0 != 1) begin
      bad++;
      $display("FAIL read_phases: psel %0d penable %0d want 2 1", psel_cnt - p0, pen_cnt - e0);
    end
    total++;
    if (rsp_rdata !== e.rdata || rsp_error !== e.err) begin
      bad++;
      $display("FAIL read_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_error, e.rdata, e.err);
    end
    total++;
    if (stab_err != s0 || PADDR !== 32'h4 || PSEL !== 1'b0) begin
      bad++;
      $display("FAIL read_bus: stab %0d paddr %h psel %b want 0 4 0", stab_err - s0, PADDR, PSEL);
    end
    @(negedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL read_hold: valid %b rdata %h want 0 12345678", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_write;
    int cyc, s0;
    bit got;
    exp_t e;
    wait_cycles = 0;
    slv_rdata = 32'hFFFF_FFFF;
    slv_err = 1'b0;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    s0 = stab_err;
    issue_req(1'b1, 32'h0, 32'hA5A5_0001);
    wait_rsp(cyc, got);
    e = sb.pop_front();
    total++;
    if (!got || cyc != 3) begin
      bad++;
      $display("FAIL write_latency: got %0d (seen %b) want 3", cyc, got);
    end
    total++;
    if (rsp_rdata !== e.rdata || rsp_error !== e.err) begin
      bad++;
      $display("FAIL write_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_error, e.rdata, e.err);
    end
    total++;
    if (snap_write !== 1'b1 || snap_wdata !== 32'hA5A5_0001 || stab_err != s0) begin
      bad++;
      $display("FAIL write_bus: pwrite %b pwdata %h stab %0d want 1 a5a50001 0",
               snap_write, snap_wdata, stab_err - s0);
    end
    total++;
    if (PWRITE !== 1'b1 || PWDATA !== 32'hA5A5_0001 || PADDR !== 32'h0) begin
      bad++;
      $display("FAIL write_hold: pwrite %b pwdata %h paddr %h", PWRITE, PWDATA, PADDR);
    end
  endtask

  task automatic test_wait_err;
    int cyc, e0;
    bit got;
    exp_t e;
    wait_cycles = 3;
    slv_rdata = 32'hCAFE_F00D;
    slv_err = 1'b1;
    sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b1});
    e0 = pen_cnt;
    issue_req(1'b0, 32'h10, 32'h0);
    wait_rsp(cyc, got);
    e = sb.pop_front();
    total++;
    if (!got || cyc != 6 || pen_cnt - e0 != 4) begin
      bad++;
      $display("FAIL wait_timing: latency %0d access %0d want 6 4", cyc, pen_cnt - e0);
    end
    total++;
    if (rsp_rdata !== e.rdata || rsp_error !== e.err) begin
      bad++;
      $display("FAIL wait_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_error, e.rdata, e.err);
    end
    wait_cycles = 0;
    slv_err = 1'b0;
  endtask

  task automatic test_timeout;
    int cyc, e0;
    bit got;
    exp_t e;
    stuck = 1'b1;
    sb.push_back('{rdata: 32'hBAD1_BAD1, err: 1'b1});
    e0 = pen_cnt;
    issue_req(1'b0, 32'h20, 32'h0);
    wait_rsp(cyc, got);
    e = sb.pop_front();
    total++;
    if (!got || cyc != 18 || pen_cnt - e0 != 16) begin
      bad++;
      $display("FAIL timeout_timing: latency %0d access %0d want 18 16", cyc, pen_cnt - e0);
    end
    total++;
    if (rsp_rdata !== e.rdata || rsp_error !== e.err || PSEL !== 1'b0) begin
      bad++;
      $display("FAIL timeout_rsp: got %h/%b psel %b want %h/%b 0",
               rsp_rdata, rsp_error, PSEL, e.rdata, e.err);
    end
    stuck = 1'b0;
  endtask

  task automatic test_misaligned;
    int cyc, p0;
    bit got;
    exp_t e;
    sb.push_back('{rdata: 32'hBAD1_BAD1, err: 1'b1});
    p0 = psel_cnt;
    issue_req(1'b0, 32'h6, 32'h0);
    wait_rsp(cyc, got);
    e = sb.pop_front();
    total++;
    if (!got || cyc != 1 || psel_cnt != p0) begin
      bad++;
      $display("FAIL misalign_timing: latency %0d psel %0d want 1 0", cyc, psel_cnt - p0);
    end
    total++;
    if (rsp_rdata !== e.rdata || rsp_error !== e.err) begin
      bad++;
      $display("FAIL misalign_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_error, e.rdata, e.err);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit got;
    exp_t e;
    slv_rdata = 32'h1111_0000;
    sb.push_back('{rdata: 32'h1111_0000, err: 1'b0});
    issue_req(1'b0, 32'h8, 32'h0);
    wait_rsp(cyc, got);
    e = sb.pop_front();
    total++;
    if (!got || rsp_rdata !== e.rdata || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: rdata %h ready %b want %h 1", rsp_rdata, req_ready, e.rdata);
    end
    // Issue the next request in the response cycle itself.
    slv_rdata = 32'h2222_0000;
    sb.push_back('{rdata: 32'h2222_0000, err: 1'b0});
    issue_req(1'b0, 32'hC, 32'h0);
    wait_rsp(cyc, got);
    e = sb.pop_front();
    total++;
    if (!got || cyc != 3 || rsp_rdata !== e.rdata || PADDR !== 32'hC) begin
      bad++;
      $display("FAIL b2b_second: latency %0d rdata %h paddr %h want 3 %h c",
               cyc, rsp_rdata, PADDR, e.rdata);
    end
  endtask

  task automatic test_reset_abort;
    int cyc, r0;
    bit got;
    bit in_access;
    exp_t e;
    stuck = 1'b1;
    in_access = 1'b0;
    issue_req(1'b0, 32'h30, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (PENABLE) begin
        in_access = 1'b1;
        break;
      end
    end
    total++;
    if (!in_access) begin
      bad++;
      $display("FAIL abort_reach_access: penable %b want 1", PENABLE);
    end
    r0 = rsp_cnt;
    #1;
    n_rst = 1'b0;
    #1;
    total++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      bad++;
      $display("FAIL abort_async: psel %b penable %b want 0 0", PSEL, PENABLE);
    end
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (rsp_cnt != r0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_rsp: rsp pulses %0d ready %b want 0 1", rsp_cnt - r0, req_ready);
    end
    slv_rdata = 32'h0BAD_F00D;
    sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
    issue_req(1'b0, 32'h4, 32'h0);
    wait_rsp(cyc, got);
    e = sb.pop_front();
    total++;
    if (!got || cyc != 3 || rsp_rdata !== e.rdata || rsp_error !== e.err) begin
      bad++;
      $display("FAIL abort_recover: latency %0d rsp %h/%b want 3 %h/%b",
               cyc, rsp_rdata, rsp_error, e.rdata, e.err);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_wait_err();
    test_timeout();
    test_misaligned();
    test_back_to_back();
    test_reset_abort();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
